// File: rtl/regfile_wb.sv
// 32 x 32-bit architectural register file written from the MEM/WB register.
// Two combinational read ports with same-cycle write bypass, plus commit trace.
module regfile_wb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              trace_valid,
    output logic [ADDR_W-1:0] trace_addr,
    output logic [DATA_W-1:0] trace_data,
    output logic [CNT_W-1:0]  commit_cnt
);

    localparam int unsigned NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic              arch_wr_c;

    // A write to $zero is not architectural: no state change, no trace, no count.
    assign arch_wr_c = !rst && we && (waddr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
            trace_valid <= 1'b0;
            trace_addr  <= '0;
            trace_data  <= '0;
            commit_cnt  <= '0;
        end else begin
            trace_valid <= arch_wr_c;
            if (arch_wr_c) begin
                regs[waddr] <= wdata;
                trace_addr  <= waddr;
                trace_data  <= wdata;
                commit_cnt  <= commit_cnt + CNT_W'(1);
            end
        end
    end

    // Read port 1: reset, disable and $zero force 0; bypass beats array contents.
    always_comb begin
        rdata1 = '0;
        if (!rst && re1 && (raddr1 != '0)) begin
            if (we && (waddr == raddr1)) begin
                rdata1 = wdata;
            end else begin
                rdata1 = regs[raddr1];
            end
        end
    end

    // Read port 2: identical priority to port 1, fully independent.
    always_comb begin
        rdata2 = '0;
        if (!rst && re2 && (raddr2 != '0)) begin
            if (we && (waddr == raddr2)) begin
                rdata2 = wdata;
            end else begin
                rdata2 = regs[raddr2];
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb.sv
// Directed self-checking bench for regfile_wb with hand-computed expectations.
module tb_regfile_wb;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        trace_valid;
    logic [4:0]  trace_addr;
    logic [31:0] trace_data;
    logic [31:0] commit_cnt;

    int n_cmp = 0;
    int n_err = 0;

    regfile_wb dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .re1        (re1),
        .raddr1     (raddr1),
        .rdata1     (rdata1),
        .re2        (re2),
        .raddr2     (raddr2),
        .rdata2     (rdata2),
        .trace_valid(trace_valid),
        .trace_addr (trace_addr),
        .trace_data (trace_data),
        .commit_cnt (commit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;

        // Reset with a concurrent write that must be lost
        tick();
        #1 check("rd_in_reset", rdata1, 32'h0);
        check("rd2_in_reset", rdata2, 32'h0);
        tick();
        rst = 1'b0; we = 1'b0;
        #1 check("rst_rd5", rdata1, 32'h0);
        check("rst_cnt", commit_cnt, 32'd0);
        check("rst_tv", 32'(trace_valid), 32'd0);
        check("rst_taddr", 32'(trace_addr), 32'd0);
        check("rst_tdata", trace_data, 32'h0);

        // Basic write then read
        wr(5'd3, 32'h12345678);
        raddr1 = 5'd3;
        #1 check("basic_rd", rdata1, 32'h12345678);
        check("basic_tv", 32'(trace_valid), 32'd1);
        check("basic_taddr", 32'(trace_addr), 32'd3);
        check("basic_tdata", trace_data, 32'h12345678);
        check("basic_cnt", commit_cnt, 32'd1);
        tick();
        #1 check("basic_tv_drop", 32'(trace_valid), 32'd0);
        check("basic_taddr_hold", 32'(trace_addr), 32'd3);

        // Bypass on both ports in the write cycle
        we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
        re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd7; raddr2 = 5'd7;
        #1 check("byp_rd1", rdata1, 32'hA5A5A5A5);
        check("byp_rd2", rdata2, 32'hA5A5A5A5);
        tick();
        we = 1'b0;
        #1 check("byp_after_rd1", rdata1, 32'hA5A5A5A5);
        check("byp_cnt", commit_cnt, 32'd2);

        // Bypass on port 2 only while port 1 reads a stored register
        we = 1'b1; waddr = 5'd8; wdata = 32'h0BADF00D;
        raddr1 = 5'd3; raddr2 = 5'd8;
        #1 check("mix_rd1", rdata1, 32'h12345678);
        check("mix_rd2", rdata2, 32'h0BADF00D);
        tick();
        we = 1'b0;
        #1 check("mix_cnt", commit_cnt, 32'd3);

        // Writes to $zero are discarded
        tick();
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr1 = 5'd0;
        #1 check("zero_rd_same", rdata1, 32'h0);
        tick();
        we = 1'b0;
        #1 check("zero_rd_next", rdata1, 32'h0);
        check("zero_cnt", commit_cnt, 32'd3);
        check("zero_tv", 32'(trace_valid), 32'd0);
        check("zero_tdata_hold", trace_data, 32'h0BADF00D);

        // Read enable gating
        wr(5'd4, 32'h55);
        re2 = 1'b0; raddr2 = 5'd4;
        #1 check("re2_off", rdata2, 32'h0);
        re2 = 1'b1;
        #1 check("re2_on", rdata2, 32'h55);
        re1 = 1'b0; raddr1 = 5'd3;
        #1 check("re1_off", rdata1, 32'h0);
        re1 = 1'b1;

        // Back-to-back overwrite of reg 9
        wr(5'd9, 32'd1);
        wr(5'd9, 32'd2);
        wr(5'd9, 32'd3);
        raddr1 = 5'd9;
        #1 check("ovw_rd", rdata1, 32'd3);
        check("ovw_cnt", commit_cnt, 32'd7);
        check("ovw_tv", 32'(trace_valid), 32'd1);
        check("ovw_taddr", 32'(trace_addr), 32'd9);
        check("ovw_tdata", trace_data, 32'd3);

        // Mid-stream reset with a concurrent write
        rst = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'h77;
        #1 check("mrst_rd_during", rdata1, 32'h0);
        tick();
        rst = 1'b0; we = 1'b0;
        #1 check("mrst_rd9", rdata1, 32'h0);
        raddr2 = 5'd3;
        #1 check("mrst_rd3", rdata2, 32'h0);
        check("mrst_cnt", commit_cnt, 32'd0);
        check("mrst_tv", 32'(trace_valid), 32'd0);
        check("mrst_tdata", trace_data, 32'h0);

        // Register survives idle cycles after reset recovery
        wr(5'd31, 32'hCAFEBABE);
        tick();
        tick();
        raddr1 = 5'd31;
        #1 check("hold_rd31", rdata1, 32'hCAFEBABE);
        check("hold_cnt", commit_cnt, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Architectural general-purpose register file: 32 x 32-bit.
- Sits at the consumer end of the writeback stage. Its write port is driven directly by the MEM/WB pipeline register outputs (destination address, write-enable, write data).
- Serves two combinational read ports to the ID stage, with same-cycle write-to-read bypass.
- Provides a committed-write trace and commit counter for difftest/debug.

Parameters:
- DATA_W, 32, register and data width.
- ADDR_W, 5, register address width (2^ADDR_W registers).
- CNT_W, 32, width of the commit counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- we  in  1  write enable from WB stage.
- waddr  in  ADDR_W  write destination register.
- wdata  in  DATA_W  write data.
- re1  in  1  read port 1 enable.
- raddr1  in  ADDR_W  read port 1 address.
- rdata1  out  DATA_W  read port 1 data (combinational).
- re2  in  1  read port 2 enable.
- raddr2  in  ADDR_W  read port 2 address.
- rdata2  out  DATA_W  read port 2 data (combinational).
- trace_valid  out  1  registered; high for one cycle after an architectural write commits.
- trace_addr  out  ADDR_W  registered; address of the last committed write.
- trace_data  out  DATA_W  registered; data of the last committed write.
- commit_cnt  out  CNT_W  registered; count of architectural writes since reset.

Behaviour:
- Reset:
  - Synchronous, active-high, sampled on the rising edge of clk.
  - On a reset edge: all 32 registers <= 0, trace_valid <= 0, trace_addr <= 0, trace_data <= 0, commit_cnt <= 0.
  - While rst is high: writes are ignored and rdata1/rdata2 = 0 regardless of other inputs.
- Architectural write:
  - Defined as rst=0 && we=1 && waddr != 0.
  - reg[waddr] <= wdata at the rising edge; 1-cycle write latency.
- Register 0:
  - Hardwired to zero; never written.
  - A write with waddr=0 is discarded: no trace_valid pulse, no commit_cnt increment.
- Read port n (n = 1, 2), combinational, in priority order:
  1. rst=1 -> 0.
  2. re_n=0 -> 0.
  3. raddr_n=0 -> 0.
  4. we=1 and waddr=raddr_n -> wdata (bypass: the value being written this cycle).
  5. Otherwise reg[raddr_n].
- Both read ports are independent. Both may read the same address, and both may hit the bypass at the same time.
- Trace:
  - Each cycle with rst=0: trace_valid <= architectural write.
  - On an architectural write: trace_addr <= waddr, trace_data <= wdata.
  - Otherwise trace_addr/trace_data hold their previous values.
- Commit counter:
  - commit_cnt <= commit_cnt + 1 on each architectural write.
  - Wraps modulo 2^CNT_W with no saturation.
- Reset asserted mid-stream:
  - A write presented in the same cycle as rst=1 is lost.
  - The register contents and counters are cleared.
- Back-to-back writes to the same register: last write wins; each one pulses the trace and increments the counter.
- No X propagation: every output is defined under any combination of the enables.

Test Plan:
- Reset: rst=1 for 2 cycles with we=1, waddr=5, wdata=0xDEADBEEF. Release, then read re1=1, raddr1=5 -> rdata1=0, commit_cnt=0, trace_valid=0.
- Basic write/read:
  - Write we=1, waddr=3, wdata=0x12345678; next cycle we=0, re1=1, raddr1=3 -> rdata1=0x12345678.
  - trace_valid=1, trace_addr=3, trace_data=0x12345678, commit_cnt=1.
  - The following cycle trace_valid=0.
- Bypass: we=1, waddr=7, wdata=0xA5A5A5A5 with re1=re2=1, raddr1=raddr2=7 in the same cycle -> rdata1=rdata2=0xA5A5A5A5 combinationally, before the edge.
- $zero:
  - we=1, waddr=0, wdata=0xFFFFFFFF, with re1=1, raddr1=0 in the same and the next cycle -> rdata1=0 in both.
  - commit_cnt unchanged, trace_valid stays 0.
- Read enable: reg 4 holds 0x55; re2=0, raddr2=4 -> rdata2=0. Set re2=1 -> rdata2=0x55.
- Counter/overwrite:
  - 3 consecutive writes to reg 9 (values 1, 2, 3) -> reg 9 = 3 and commit_cnt +3.
  - Then rst=1 for one cycle concurrent with a write of 0x77 to reg 9 -> reg 9 = 0 and commit_cnt=0.
